// File: rtl/n_bit_adder_pkg.sv
// Shared constants for the ripple-carry adder block.
package n_bit_adder_pkg;

  localparam int unsigned DEFAULT_N   = 17;
  localparam int unsigned ZERO_RESULT = 0;

endpackage

// File: rtl/n_bit_adder_full_adder.sv
// One-bit full adder cell; chained by n_bit_adder to form the ripple carry.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic w_half;

  assign w_half = a ^ b;
  assign s      = w_half ^ cin;
  assign cout   = (a & b) | (cin & w_half);

endmodule

// File: rtl/n_bit_adder.sv
// N-bit ripple-carry adder with a combinational sum and a registered result
// stage carrying sum, unsigned carry-out and signed-overflow flags.
module n_bit_adder
  import n_bit_adder_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] input1,
  input  logic [N-1:0] input2,
  input  logic         in_valid,
  output logic [N-1:0] answer,
  output logic [N-1:0] sum_q,
  output logic         carry_q,
  output logic         ovf_q,
  output logic         out_valid
);

  logic [N:0]   w_carry;
  logic [N-1:0] w_sum;
  logic         w_ovf;

  logic [N-1:0] r_sum;
  logic         r_carry;
  logic         r_ovf;
  logic         r_valid;

  assign w_carry[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_stage
    full_adder u_fa (
      .a    (input1[i]),
      .b    (input2[i]),
      .cin  (w_carry[i]),
      .s    (w_sum[i]),
      .cout (w_carry[i+1])
    );
  end

  // Overflow only when both addends share a sign and the result's sign differs.
  assign w_ovf  = (input1[N-1] == input2[N-1]) && (w_sum[N-1] != input1[N-1]);
  assign answer = w_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum   <= N'(ZERO_RESULT);
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_sum   <= w_sum;
        r_carry <= w_carry[N];
        r_ovf   <= w_ovf;
      end
    end
  end

  assign sum_q     = r_sum;
  assign carry_q   = r_carry;
  assign ovf_q     = r_ovf;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_n_bit_adder.sv
// Directed and randomized checks of n_bit_adder at N=17.
module tb_n_bit_adder;

  localparam int N = 17;

  logic         clk;
  logic         rst;
  logic [N-1:0] input1;
  logic [N-1:0] input2;
  logic         in_valid;
  logic [N-1:0] answer;
  logic [N-1:0] sum_q;
  logic         carry_q;
  logic         ovf_q;
  logic         out_valid;

  int checks;
  int errors;

  n_bit_adder #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .input1    (input1),
    .input2    (input2),
    .in_valid  (in_valid),
    .answer    (answer),
    .sum_q     (sum_q),
    .carry_q   (carry_q),
    .ovf_q     (ovf_q),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drives operands at the falling edge so they settle well before capture.
  task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b,
                               input logic v, input logic r);
    @(negedge clk);
    input1   = a;
    input2   = b;
    in_valid = v;
    rst      = r;
    #1;
  endtask

  task automatic checkRegs(input string tag, input logic [N-1:0] s,
                           input logic c, input logic o, input logic v);
    checkOutput({tag, "_sum_q"}, 32'(sum_q), 32'(s));
    checkOutput({tag, "_carry_q"}, 32'(carry_q), 32'(c));
    checkOutput({tag, "_ovf_q"}, 32'(ovf_q), 32'(o));
    checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'(v));
  endtask

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] s;
    logic         c;
    logic         o;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [N-1:0] ra, rb;
    logic [N:0]   full;
    int           sa, sb, ssum;

    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    input1   = '0;
    input2   = '0;

    vecs[0] = '{17'h00005, 17'h00003, 17'h00008, 1'b0, 1'b0};
    vecs[1] = '{17'h1FFFF, 17'h00001, 17'h00000, 1'b1, 1'b0};
    vecs[2] = '{17'h0FFFF, 17'h00001, 17'h10000, 1'b0, 1'b1};
    vecs[3] = '{17'h10000, 17'h10000, 17'h00000, 1'b1, 1'b1};
    vecs[4] = '{17'h1FFFD, 17'h00007, 17'h00004, 1'b1, 1'b0};

    applyStimulus(17'h00000, 17'h00000, 1'b0, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkRegs("reset", 17'h0, 1'b0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].a, vecs[i].b, 1'b1, 1'b0);
      checkOutput($sformatf("v%0d_answer", i), 32'(answer), 32'(vecs[i].s));
      @(posedge clk); #1;
      checkRegs($sformatf("v%0d", i), vecs[i].s, vecs[i].c, vecs[i].o, 1'b1);
    end

    // Operands move with in_valid low: only answer may follow.
    applyStimulus(17'h00100, 17'h00200, 1'b0, 1'b0);
    checkOutput("hold_answer", 32'(answer), 32'h300);
    @(posedge clk); #1;
    checkRegs("hold", 17'h00004, 1'b1, 1'b0, 1'b0);

    applyStimulus(17'h00010, 17'h00020, 1'b1, 1'b1);
    checkOutput("rst_answer_pre", 32'(answer), 32'h30);
    @(posedge clk); #1;
    checkRegs("rst_prio", 17'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_answer_post", 32'(answer), 32'h30);

    applyStimulus(17'h12345, 17'h00001, 1'b1, 1'b0);
    checkOutput("resume_answer", 32'(answer), 32'h12346);
    @(posedge clk); #1;
    checkRegs("resume", 17'h12346, 1'b0, 1'b0, 1'b1);

    for (int k = 0; k < 100; k++) begin
      ra = N'($urandom_range(0, 32'h1FFFF));
      rb = N'($urandom_range(0, 32'h1FFFF));
      applyStimulus(ra, rb, 1'b1, 1'b0);
      full = {1'b0, ra} + {1'b0, rb};
      sa   = ra[N-1] ? int'(ra) - 131072 : int'(ra);
      sb   = rb[N-1] ? int'(rb) - 131072 : int'(rb);
      ssum = sa + sb;
      @(posedge clk); #1;
      checkRegs($sformatf("rand%0d", k), full[N-1:0], full[N],
                (ssum > 65535) || (ssum < -65536), 1'b1);
    end

    applyStimulus(17'h00000, 17'h00000, 1'b0, 1'b0);
    @(posedge clk); #1;
    checkOutput("final_out_valid", 32'(out_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
